// File: rtl/mil_queue_pkg.sv
// Shared types for the MIL transmit frame queue: stored entry layout and read FSM states.
package mil_queue_pkg;

  localparam int MIL_WORD_W = 16;
  localparam int ENTRY_W    = MIL_WORD_W + 2;

  typedef struct packed {
    logic                  last;
    logic                  cmd;
    logic [MIL_WORD_W-1:0] data;
  } mil_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } read_state_t;

endpackage

// File: rtl/mil_queue_ram.sv
// Simple dual-port word store for the frame queue; synchronous write, registered read with enable.
module mil_queue_ram
  import mil_queue_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rdata_q;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read register is cleared so no stale word is visible after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mil_tx_frame_queue.sv
// Store-and-forward MIL-STD-1553 frame queue: buffers whole frames, drops overflowing ones
// atomically and replays complete frames with a fixed inter-frame gap.
module mil_tx_frame_queue
  import mil_queue_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int MAX_FRAMES = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [MIL_WORD_W-1:0]         in_data,
  input  logic                          in_cmd,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [MIL_WORD_W-1:0]         out_data,
  output logic                          out_cmd,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        words_used,
  output logic [$clog2(MAX_FRAMES):0]   frames_ready,
  output logic                          drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES) + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_base_q, wr_base_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] part_cnt_q, part_cnt_d, words_used_q, words_used_d;
  logic [FW-1:0] frames_ready_q, frames_ready_d, frames_held;
  logic [GW-1:0] gap_q, gap_d;
  logic          frame_done_q, frame_done_d, discard_q, discard_d, drop_q, drop_d;
  logic          out_valid_q, out_valid_d, in_ready_q;
  read_state_t   state_q, state_d;

  logic               ram_we, ram_re, wr_inc, rd_dec, flush, frame_sent;
  logic [ENTRY_W-1:0] ram_rdata;
  mil_entry_t         rd_entry;

  mil_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({in_last, in_cmd, in_data}),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign rd_entry = mil_entry_t'(ram_rdata);

  // write side: a frame completing this cycle becomes visible in frames_ready one cycle later,
  // so the capacity check counts that pending completion too
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_base_d    = wr_base_q;
    part_cnt_d   = part_cnt_q;
    discard_d    = discard_q;
    drop_d       = 1'b0;
    frame_done_d = 1'b0;
    ram_we       = 1'b0;
    wr_inc       = 1'b0;
    flush        = 1'b0;
    frames_held  = frames_ready_q + FW'(frame_done_q);
    if (in_valid) begin
      if (discard_q) begin
        if (in_last) begin
          discard_d = 1'b0;
          drop_d    = 1'b1;
        end else begin
          discard_d = 1'b1;
        end
      end else if ((words_used_q == CW'(DEPTH)) ||
                   (in_last && (frames_held == FW'(MAX_FRAMES)))) begin
        flush      = 1'b1;
        wr_ptr_d   = wr_base_q;
        part_cnt_d = '0;
        if (in_last) begin
          drop_d = 1'b1;
        end else begin
          discard_d = 1'b1;
        end
      end else begin
        ram_we   = 1'b1;
        wr_inc   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (in_last) begin
          wr_base_d    = wr_ptr_q + AW'(1);
          part_cnt_d   = '0;
          frame_done_d = 1'b1;
        end else begin
          part_cnt_d = part_cnt_q + CW'(1);
        end
      end
    end else begin
      discard_d = discard_q;
    end
  end

  // read FSM: the next entry is prefetched as each non-last word is accepted
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    ram_re      = 1'b0;
    rd_dec      = 1'b0;
    frame_sent  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((frames_ready_q != '0) && (gap_q == '0)) begin
          ram_re      = 1'b1;
          rd_ptr_d    = rd_ptr_q + AW'(1);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          rd_dec = 1'b1;
          if (rd_entry.last) begin
            frame_sent  = 1'b1;
            out_valid_d = 1'b0;
            gap_d       = GW'(GAP_CYCLES);
            state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // occupancy counters reflect the net effect of write, read and discard in one cycle
  always_comb begin
    words_used_d   = words_used_q + CW'(wr_inc) - CW'(rd_dec) - (flush ? part_cnt_q : CW'(0));
    frames_ready_d = frames_ready_q + FW'(frame_done_q) - FW'(frame_sent);
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      wr_base_q      <= '0;
      rd_ptr_q       <= '0;
      part_cnt_q     <= '0;
      words_used_q   <= '0;
      frames_ready_q <= '0;
      gap_q          <= '0;
      frame_done_q   <= 1'b0;
      discard_q      <= 1'b0;
      drop_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b0;
      state_q        <= IDLE;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      wr_base_q      <= wr_base_d;
      rd_ptr_q       <= rd_ptr_d;
      part_cnt_q     <= part_cnt_d;
      words_used_q   <= words_used_d;
      frames_ready_q <= frames_ready_d;
      gap_q          <= gap_d;
      frame_done_q   <= frame_done_d;
      discard_q      <= discard_d;
      drop_q         <= drop_d;
      out_valid_q    <= out_valid_d;
      in_ready_q     <= 1'b1;
      state_q        <= state_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = rd_entry.data;
  assign out_cmd      = rd_entry.cmd;
  assign out_last     = rd_entry.last;
  assign words_used   = words_used_q;
  assign frames_ready = frames_ready_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_mil_tx_frame_queue.sv
// Self-checking bench for mil_tx_frame_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_mil_tx_frame_queue;

  localparam int DEPTH = 64;
  localparam int MAXF  = 8;
  localparam int GAP   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_cmd, in_last, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_cmd, out_last, out_ready;
  logic [15:0] out_data;
  logic [6:0]  words_used;
  logic [3:0]  frames_ready;
  logic        drop;

  mil_tx_frame_queue #(.DEPTH(DEPTH), .MAX_FRAMES(MAXF), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_cmd(in_cmd), .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_cmd(out_cmd), .out_last(out_last),
    .out_ready(out_ready),
    .words_used(words_used), .frames_ready(frames_ready), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [17:0] mbuf[$];     // words held, oldest first; the presented word is mbuf[0]
  int          m_part;      // words of the frame still being written
  logic        m_disc, m_drop, m_valid, m_in_ready, m_started;
  logic [17:0] m_out;
  int          m_fr, m_pend, cyc, issue_ok;

  task automatic model_step();
    int   pre_size, held;
    logic done_now, consumed;
    cyc++;
    if (rst) begin
      mbuf.delete();
      m_part = 0; m_disc = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_out = 18'd0;
      m_fr = 0; m_pend = 0; issue_ok = 0; m_in_ready = 1'b0; m_started = 1'b1;
      return;
    end
    pre_size = mbuf.size();
    held     = m_fr + m_pend;
    done_now = 1'b0;
    consumed = 1'b0;
    m_drop   = 1'b0;
    if (in_valid) begin
      if (m_disc) begin
        if (in_last) begin m_disc = 1'b0; m_drop = 1'b1; end
      end else if (pre_size == DEPTH || (in_last && held == MAXF)) begin
        repeat (m_part) void'(mbuf.pop_back());
        m_part = 0;
        if (in_last) m_drop = 1'b1; else m_disc = 1'b1;
      end else begin
        mbuf.push_back({in_last, in_cmd, in_data});
        if (in_last) begin m_part = 0; done_now = 1'b1; end
        else m_part++;
      end
    end
    if (m_valid) begin
      if (out_ready) begin
        void'(mbuf.pop_front());
        if (m_out[17]) begin
          consumed = 1'b1;
          m_valid  = 1'b0;
          issue_ok = cyc + GAP + 1;
        end else if (mbuf.size() > 0) begin
          m_out = mbuf[0];
        end
      end
    end else if (m_fr > 0 && cyc >= issue_ok && mbuf.size() > 0) begin
      m_valid = 1'b1;
      m_out   = mbuf[0];
    end
    m_fr       = m_fr + m_pend - int'(consumed);
    m_pend     = int'(done_now);
    m_in_ready = 1'b1;
  endtask

  initial begin
    m_started = 1'b0; cyc = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // compare every cycle once the model has seen reset
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_word", 32'({out_last, out_cmd, out_data}), 32'(m_out));
        chk("in_ready", 32'(in_ready), 32'(m_in_ready));
        chk("words_used", 32'(words_used), 32'(mbuf.size()));
        chk("frames_ready", 32'(frames_ready), 32'(m_fr));
        chk("drop", 32'(drop), 32'(m_drop));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_word(input logic [15:0] d, input logic c, input logic l);
    in_valid = 1'b1; in_data = d; in_cmd = c; in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int budget, input logic [3:0] pat, output int cnt);
    int k;
    cnt = 0;
    k = 0;
    while ((frames_ready != 4'd0 || out_valid) && k < budget) begin
      out_ready = pat[k % 4];
      if (out_valid && out_ready) cnt++;
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, 32'(k < budget), 32'd1);
    out_ready = 1'b1;
  endtask

  int cnt, k, gap_cnt, rem, pos;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_cmd = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_words", 32'(words_used), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // single frame: latency and consecutive output
    drive_word(16'h0C21, 1'b1, 1'b0);
    drive_word(16'h1234, 1'b0, 1'b0);
    drive_word(16'hABCD, 1'b0, 1'b1);
    chk("t1_fr_edge_n", 32'(frames_ready), 32'd0);
    chk("t1_words_edge_n", 32'(words_used), 32'd3);
    @(negedge clk);
    chk("t1_fr_n1", 32'(frames_ready), 32'd1);
    chk("t1_valid_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n2", 32'(out_valid), 32'd1);
    chk("t1_w0", 32'({out_last, out_cmd, out_data}), 32'h10C21);
    @(negedge clk);
    chk("t1_w1", 32'({out_valid, out_last, out_cmd, out_data}), 32'h41234);
    @(negedge clk);
    chk("t1_w2", 32'({out_valid, out_last, out_cmd, out_data}), 32'h6ABCD);
    @(negedge clk);
    chk("t1_valid_end", 32'(out_valid), 32'd0);
    chk("t1_fr_end", 32'(frames_ready), 32'd0);
    chk("t1_words_end", 32'(words_used), 32'd0);
    idle(20);

    // two frames back-to-back: inter-frame gap
    for (int i = 0; i < 3; i++) drive_word(16'hA000 + 16'(i), (i == 0), (i == 2));
    for (int i = 0; i < 2; i++) drive_word(16'hB000 + 16'(i), (i == 0), (i == 1));
    k = 0;
    while (!(out_valid && out_last) && k < 100) begin @(negedge clk); k++; end
    chk("t2_last_seen", 32'(out_valid && out_last), 32'd1);
    chk("t2_last_data", 32'(out_data), 32'hA002);
    gap_cnt = 0;
    @(negedge clk);
    while (!out_valid && gap_cnt < 100) begin gap_cnt++; @(negedge clk); end
    chk("t2_gap_cycles", 32'(gap_cnt), 32'(GAP + 1));
    chk("t2_b_first", 32'(out_data), 32'hB000);
    idle(25);

    // overflow: 60-word frame held, 10-word frame discarded
    out_ready = 1'b0;
    for (int i = 0; i < 60; i++) drive_word(16'(i), (i == 0), (i == 59));
    for (int i = 0; i < 10; i++) drive_word(16'h5000 + 16'(i), (i == 0), (i == 9));
    chk("t3_drop", 32'(drop), 32'd1);
    chk("t3_words", 32'(words_used), 32'd60);
    @(negedge clk);
    chk("t3_drop_pulse", 32'(drop), 32'd0);
    chk("t3_fr", 32'(frames_ready), 32'd1);
    drain("t3_drain", 500, 4'b1111, cnt);
    chk("t3_count", 32'(cnt), 32'd60);
    idle(20);

    // backpressure 1,0,0,1
    for (int i = 0; i < 6; i++) drive_word(16'hC000 + 16'(i), (i == 0), (i == 5));
    idle(2);
    drain("t4_drain", 200, 4'b1001, cnt);
    chk("t4_count", 32'(cnt), 32'd6);
    idle(20);

    // frame-count limit
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive_word(16'h7000 + 16'(i), 1'b1, 1'b1);
    chk("t5_drop", 32'(drop), 32'd1);
    @(negedge clk);
    chk("t5_fr", 32'(frames_ready), 32'd8);
    chk("t5_words", 32'(words_used), 32'd8);
    drain("t5_drain", 400, 4'b1111, cnt);
    chk("t5_count", 32'(cnt), 32'd8);
    idle(20);

    // reset during the third word of an in-flight output frame
    for (int i = 0; i < 5; i++) drive_word(16'hD000 + 16'(i), (i == 0), (i == 4));
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    idle(2);
    chk("t6_third_word", 32'(out_data), 32'hD002);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_words", 32'(words_used), 32'd0);
    chk("t6_rst_fr", 32'(frames_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    drive_word(16'hE000, 1'b1, 1'b0);
    drive_word(16'hE001, 1'b0, 1'b1);
    idle(2);
    chk("t6_new_first", 32'({out_valid, out_data}), 32'h1E000);
    drain("t6_drain", 50, 4'b1111, cnt);
    chk("t6_count", 32'(cnt), 32'd2);

    // randomized traffic
    rem = 0; pos = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 400; c++) begin
        case (ph)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          2:       out_ready = ($urandom_range(0, 9) == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (rem == 0) begin
          rem = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 8);
          pos = 0;
        end
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
        in_cmd   = (pos == 0);
        in_last  = (rem == 1);
        if (in_valid) begin rem--; pos++; end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);
    drain("t7_drain", 3000, 4'b1111, cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
